// File: rtl/mc_pkg.sv
// Shared opcodes, instruction field positions, FSM state type and the immediate
// sign-extension helper for the mc_core_p processor.
package mc_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StHalt
  } state_e;

  localparam logic [3:0] OpSys = 4'h0;
  localparam logic [3:0] OpLi  = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpAnd = 4'h4;
  localparam logic [3:0] OpOr  = 4'h5;
  localparam logic [3:0] OpXor = 4'h6;
  localparam logic [3:0] OpShr = 4'h7;
  localparam logic [3:0] OpLd  = 4'h8;
  localparam logic [3:0] OpSt  = 4'h9;
  localparam logic [3:0] OpJz  = 4'hA;
  localparam logic [3:0] OpJr  = 4'hB;

  localparam int unsigned OpMsb  = 15;
  localparam int unsigned OpLsb  = 12;
  localparam int unsigned ImmMsb = 11;
  localparam int unsigned ImmLsb = 4;
  localparam int unsigned RsMsb  = 7;
  localparam int unsigned RsLsb  = 4;
  localparam int unsigned RdMsb  = 3;
  localparam int unsigned RdLsb  = 0;

  // Wide result; callers truncate to the register or pc width with a size cast.
  function automatic logic [63:0] sext8(input logic [7:0] v);
    return {{56{v[7]}}, v};
  endfunction

endpackage

// File: rtl/mc_core_p_if.sv
// Instruction and data memory req/ack buses of mc_core_p; the core is the master.
interface mc_core_p_if #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned IADDR_W = 16,
    parameter int unsigned DADDR_W = 16
);
    logic               imem_req;
    logic [IADDR_W-1:0] imem_addr;
    logic               imem_ack;
    logic [15:0]        imem_rdata;
    logic               dmem_req;
    logic               dmem_we;
    logic [DADDR_W-1:0] dmem_addr;
    logic [WIDTH-1:0]   dmem_wdata;
    logic               dmem_ack;
    logic [WIDTH-1:0]   dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mc_alu.sv
// Combinational ALU for the register-register ops of mc_core_p.
module mc_alu
    import mc_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);
    localparam int unsigned ShW = $clog2(WIDTH);

    always_comb begin
        y_o = a_i;
        case (op_i)
            OpAdd:   y_o = a_i + b_i;
            OpSub:   y_o = a_i - b_i;
            OpAnd:   y_o = a_i & b_i;
            OpOr:    y_o = a_i | b_i;
            OpXor:   y_o = a_i ^ b_i;
            OpShr:   y_o = a_i >> b_i[ShW-1:0];
            default: y_o = a_i;
        endcase
    end
endmodule

// File: rtl/mc_core_p.sv
// Multi-cycle 16-bit-instruction core: FETCH -> DECODE -> EXEC | MEM | HALT,
// with req/ack instruction and data memory ports.
module mc_core_p
    import mc_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NREGS   = 8,
    parameter int unsigned IADDR_W = 16,
    parameter int unsigned DADDR_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    mc_core_p_if.master bus,
    output logic        halt,
    output logic        illegal,
    output logic [7:0]  sys_code
);
    localparam int unsigned RidxW = (NREGS > 1) ? $clog2(NREGS) : 1;

    state_e             state_q, state_d;
    logic [IADDR_W-1:0] pc_q, pc_d;
    logic [15:0]        ir_q, ir_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   regs_q [NREGS];
    logic [WIDTH-1:0]   regs_d [NREGS];
    logic               halt_q, halt_d;
    logic               illegal_q, illegal_d;
    logic [7:0]         sys_code_q, sys_code_d;

    logic [3:0]       op, rd, rs;
    logic [7:0]       imm8;
    logic [RidxW-1:0] rd_idx, rs_idx;
    logic             uses_s, bad_op, bad_reg;
    logic [WIDTH-1:0] alu_y;

    assign op     = ir_q[OpMsb:OpLsb];
    assign imm8   = ir_q[ImmMsb:ImmLsb];
    assign rs     = ir_q[RsMsb:RsLsb];
    assign rd     = ir_q[RdMsb:RdLsb];
    assign rd_idx = rd[RidxW-1:0];
    assign rs_idx = rs[RidxW-1:0];

    // Only fields the opcode actually reads are range-checked; sys reads none.
    assign uses_s  = (op inside {OpAdd, OpSub, OpAnd, OpOr, OpXor, OpShr, OpLd, OpSt});
    assign bad_op  = (op >= 4'hC);
    assign bad_reg = ((op != OpSys) && (32'(rd) >= NREGS)) || (uses_s && (32'(rs) >= NREGS));

    mc_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op_i (op),
        .a_i  (a_q),
        .b_i  (b_q),
        .y_o  (alu_y)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        regs_d     = regs_q;
        halt_d     = halt_q;
        illegal_d  = illegal_q;
        sys_code_d = sys_code_q;
        unique case (state_q)
            StFetch: begin
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    pc_d    = pc_q + IADDR_W'(1);
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d = regs_q[rd_idx];
                b_d = regs_q[rs_idx];
                if (bad_op || bad_reg) begin
                    halt_d    = 1'b1;
                    illegal_d = 1'b1;
                    state_d   = StHalt;
                end else if (op == OpSys) begin
                    halt_d     = 1'b1;
                    sys_code_d = imm8;
                    state_d    = StHalt;
                end else if (op == OpLd || op == OpSt) begin
                    state_d = StMem;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                case (op)
                    OpLi: regs_d[rd_idx] = WIDTH'(sext8(imm8));
                    OpAdd, OpSub, OpAnd, OpOr, OpXor, OpShr: regs_d[rd_idx] = alu_y;
                    OpJz: if (a_q == '0) pc_d = pc_q + IADDR_W'(sext8(imm8));
                    OpJr: pc_d = IADDR_W'(a_q);
                    default: ;
                endcase
                state_d = StFetch;
            end
            StMem: begin
                if (bus.dmem_ack) begin
                    if (op == OpLd) regs_d[rd_idx] = bus.dmem_rdata;
                    state_d = StFetch;
                end
            end
            StHalt: ;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StFetch;
            pc_q       <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            regs_q     <= '{default: '0};
            halt_q     <= 1'b0;
            illegal_q  <= 1'b0;
            sys_code_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            regs_q     <= regs_d;
            halt_q     <= halt_d;
            illegal_q  <= illegal_d;
            sys_code_q <= sys_code_d;
        end
    end

    // Requests are gated by reset so an in-flight access drops in the same cycle.
    assign bus.imem_req   = (state_q == StFetch) && !reset;
    assign bus.imem_addr  = pc_q;
    assign bus.dmem_req   = (state_q == StMem) && !reset;
    assign bus.dmem_we    = (op == OpSt);
    assign bus.dmem_addr  = DADDR_W'(b_q);
    assign bus.dmem_wdata = a_q;

    assign halt     = halt_q;
    assign illegal  = illegal_q;
    assign sys_code = sys_code_q;
endmodule

// File: tb/tb_mc_core_p.sv
// Directed self-checking bench for mc_core_p with wait-state memory models.
module tb_mc_core_p;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       halt, illegal;
    logic [7:0] sys_code;

    int checks = 0;
    int errors = 0;
    int ilat = 0, dlat = 0, icnt = 0, dcnt = 0;
    int cyc;

    logic [15:0] imem [256];
    logic [31:0] dmem [256];
    logic [15:0] last_fetch;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    int          wr_cnt = 0;
    int          unstable = 0;
    logic        wait_prev = 1'b0;
    logic [15:0] addr_prev;

    mc_core_p_if #(.WIDTH(32), .IADDR_W(16), .DADDR_W(16)) bus ();

    mc_core_p #(
        .WIDTH   (32),
        .NREGS   (8),
        .IADDR_W (16),
        .DADDR_W (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .halt     (halt),
        .illegal  (illegal),
        .sys_code (sys_code)
    );

    always #5 clk = ~clk;

    assign bus.imem_ack   = bus.imem_req && (icnt == ilat);
    assign bus.imem_rdata = imem[bus.imem_addr[7:0]];
    assign bus.dmem_ack   = bus.dmem_req && (dcnt == dlat);
    assign bus.dmem_rdata = dmem[bus.dmem_addr[7:0]];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            icnt <= 0;
            dcnt <= 0;
        end else begin
            icnt <= (bus.imem_req && !bus.imem_ack) ? icnt + 1 : 0;
            dcnt <= (bus.dmem_req && !bus.dmem_ack) ? dcnt + 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            wr_cnt     <= 0;
            wr_addr    <= '0;
            wr_data    <= '0;
            last_fetch <= '1;
            wait_prev  <= 1'b0;
            for (int i = 0; i < 256; i++) dmem[i] <= '0;
        end else begin
            if (bus.imem_req && bus.imem_ack) last_fetch <= bus.imem_addr;
            if (wait_prev && bus.imem_req && bus.imem_addr != addr_prev) unstable <= unstable + 1;
            wait_prev <= bus.imem_req && !bus.imem_ack;
            addr_prev <= bus.imem_addr;
            if (bus.dmem_req && bus.dmem_ack && bus.dmem_we) begin
                dmem[bus.dmem_addr[7:0]] <= bus.dmem_wdata;
                wr_cnt  <= wr_cnt + 1;
                wr_addr <= bus.dmem_addr;
                wr_data <= bus.dmem_wdata;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'h0EE0;
    endtask

    task automatic start();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_halt(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (halt) break;
        end
        check("halt_reached", halt, 1);
    endtask

    initial begin
        // Program A: li r1,5; li r2,-3; add r1,r2; sys 0x7F
        clear_imem();
        imem[0] = 16'h1051;
        imem[1] = 16'h1FD2;
        imem[2] = 16'h2021;
        imem[3] = 16'h07F0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_imem_req", bus.imem_req, 0);
        check("rst_dmem_req", bus.dmem_req, 0);
        check("rst_halt", halt, 0);
        check("rst_illegal", illegal, 0);
        check("rst_sys_code", sys_code, 0);
        check("rst_pc", dut.pc_q, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("first_req", bus.imem_req, 1);
        check("first_addr", bus.imem_addr, 0);
        wait_halt(cyc);
        check("a_cycles", cyc, 11);
        check("a_r1", dut.regs_q[1], 32'h2);
        check("a_r2_sext", dut.regs_q[2], 32'hFFFF_FFFD);
        check("a_sys_code", sys_code, 8'h7F);
        check("a_illegal", illegal, 0);
        @(negedge clk);
        check("a_no_req_halted", bus.imem_req, 0);

        // Same program with two fetch wait states
        ilat = 2;
        start();
        wait_halt(cyc);
        check("aw_cycles", cyc, 19);
        check("aw_r1", dut.regs_q[1], 32'h2);
        check("aw_sys_code", sys_code, 8'h7F);
        check("aw_addr_stable", unstable, 0);
        ilat = 0;

        // Store then load through dmem with one data wait state
        clear_imem();
        imem[0] = 16'h1103;
        imem[1] = 16'h1554;
        imem[2] = 16'h9034;
        imem[3] = 16'h8035;
        imem[4] = 16'h0000;
        dlat = 1;
        start();
        wait_halt(cyc);
        check("ls_cycles", cyc, 16);
        check("ls_wr_cnt", wr_cnt, 1);
        check("ls_wr_addr", wr_addr, 16'h0010);
        check("ls_wr_data", wr_data, 32'h55);
        check("ls_r5", dut.regs_q[5], 32'h55);
        dlat = 0;

        // ALU ops: shr, xor, and, or, sub
        clear_imem();
        imem[0] = 16'h16C1;
        imem[1] = 16'h1032;
        imem[2] = 16'h7021;
        imem[3] = 16'h10F3;
        imem[4] = 16'h6013;
        imem[5] = 16'h10A4;
        imem[6] = 16'h4014;
        imem[7] = 16'h5024;
        imem[8] = 16'h3012;
        imem[9] = 16'h0010;
        start();
        wait_halt(cyc);
        check("alu_shr", dut.regs_q[1], 32'h0D);
        check("alu_xor", dut.regs_q[3], 32'h02);
        check("alu_and_or", dut.regs_q[4], 32'h0B);
        check("alu_sub", dut.regs_q[2], 32'hFFFF_FFF6);
        check("alu_sys_code", sys_code, 8'h01);

        // jz taken / not taken, then jr
        clear_imem();
        imem[0] = 16'h1000;
        imem[1] = 16'hA020;
        imem[2] = 16'h0220;
        imem[3] = 16'h0330;
        imem[4] = 16'h0440;
        start();
        wait_halt(cyc);
        check("jz_taken_addr", last_fetch, 16'h4);
        check("jz_taken_code", sys_code, 8'h44);
        imem[0] = 16'h1010;
        start();
        wait_halt(cyc);
        check("jz_not_taken_addr", last_fetch, 16'h2);
        check("jz_not_taken_code", sys_code, 8'h22);
        imem[0] = 16'h1036;
        imem[1] = 16'hB006;
        start();
        wait_halt(cyc);
        check("jr_addr", last_fetch, 16'h3);
        check("jr_code", sys_code, 8'h33);

        // Illegal register index and illegal opcode
        clear_imem();
        imem[0] = 16'h1051;
        imem[1] = 16'h2019;
        start();
        wait_halt(cyc);
        check("ill_reg_cycles", cyc, 5);
        check("ill_reg_flag", illegal, 1);
        check("ill_reg_r1", dut.regs_q[1], 32'h5);
        check("ill_reg_sys_code", sys_code, 8'h00);
        imem[1] = 16'h2091;
        start();
        wait_halt(cyc);
        check("ill_rs_flag", illegal, 1);
        check("ill_rs_r1", dut.regs_q[1], 32'h5);
        imem[1] = 16'hE000;
        start();
        wait_halt(cyc);
        check("ill_op_flag", illegal, 1);
        check("ill_op_r1", dut.regs_q[1], 32'h5);

        // Reset while a store waits for its ack
        clear_imem();
        imem[0] = 16'h1071;
        imem[1] = 16'h9011;
        dlat = 20;
        start();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.dmem_req) break;
        end
        check("mr_dreq_seen", bus.dmem_req, 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mr_dreq_drop", bus.dmem_req, 0);
        check("mr_ireq_low", bus.imem_req, 0);
        check("mr_pc", dut.pc_q, 0);
        check("mr_r1", dut.regs_q[1], 0);
        @(negedge clk);
        reset = 1'b0;
        dlat = 0;
        #1;
        check("mr_restart_req", bus.imem_req, 1);
        check("mr_restart_addr", bus.imem_addr, 0);
        wait_halt(cyc);
        check("mr_wr_cnt", wr_cnt, 1);
        check("mr_wr_addr", wr_addr, 16'h7);
        check("mr_wr_data", wr_data, 32'h7);
        check("mr_sys_code", sys_code, 8'hEE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
